// File: rtl/gain_ramp_ctrl.sv
// gain_ramp_ctrl: owns the write port of the per-band gain register bank.
// Keeps a shadow copy of every band's current and target code, ramps the
// current code toward the target at a programmable rate, and issues one
// bank write per cycle for every band whose code changed.
module gain_ramp_ctrl #(
   parameter int         NUM_BANDS  = 10,
   parameter logic [7:0] UNITY_CODE = 8'h20,
   parameter int         STEP       = 1,
   parameter int         STEP_DIV   = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       host_valid,
   output logic       host_ready,
   input  logic [3:0] host_addr,
   input  logic [7:0] host_code,
   input  logic       ramp_en,
   output logic       we,
   output logic [7:0] addr,
   output logic [7:0] data_out,
   output logic       err,
   output logic       busy,
   output logic       init_done
);

   localparam int         PW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int         CW    = $clog2(NUM_BANDS + 1);
   localparam logic [8:0] STEP9 = 9'(STEP);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t                 state;
   logic [CW-1:0]          init_cnt;
   logic [PW-1:0]          presc;
   logic [7:0]             cur      [NUM_BANDS];
   logic [7:0]             tgt      [NUM_BANDS];
   logic [NUM_BANDS-1:0]   pend;

   logic [7:0]             cur_nxt  [NUM_BANDS];
   logic [7:0]             tgt_nxt  [NUM_BANDS];
   logic [NUM_BANDS-1:0]   pend_nxt;
   logic                   issue_found;
   int                     issue_idx;
   logic                   busy_nxt;
   logic [8:0]             up_sum;
   logic [8:0]             dn_lim;

   logic tick;
   logic accept;
   logic in_range;

   assign tick     = ramp_en && (presc == PW'(STEP_DIV - 1));
   assign accept   = host_valid && host_ready && (state == S_RUN);
   assign in_range = ({28'd0, host_addr} < 32'(NUM_BANDS));

   // Ramp prescaler: free-runs while ramping is enabled, parked at zero otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (!ramp_en || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Next shadow state: issue clears first, then tick steps and host writes set pending again
   always_comb begin
      cur_nxt     = cur;
      tgt_nxt     = tgt;
      pend_nxt    = pend;
      issue_found = 1'b0;
      issue_idx   = 0;
      up_sum      = '0;
      dn_lim      = '0;
      busy_nxt    = 1'b0;

      for (int b = NUM_BANDS - 1; b >= 0; b--) begin
         if (pend[b]) begin
            issue_found = 1'b1;
            issue_idx   = b;
         end
      end
      if (issue_found) begin
         pend_nxt[issue_idx] = 1'b0;
      end

      if (tick) begin
         for (int b = 0; b < NUM_BANDS; b++) begin
            if (cur[b] != tgt[b]) begin
               up_sum = {1'b0, cur[b]} + STEP9;
               dn_lim = {1'b0, tgt[b]} + STEP9;
               if (cur[b] < tgt[b]) begin
                  cur_nxt[b] = (up_sum >= {1'b0, tgt[b]}) ? tgt[b] : up_sum[7:0];
               end else begin
                  cur_nxt[b] = ({1'b0, cur[b]} <= dn_lim) ? tgt[b] : (cur[b] - STEP9[7:0]);
               end
               pend_nxt[b] = 1'b1;
            end
         end
      end

      if (accept && in_range) begin
         tgt_nxt[host_addr] = host_code;
         if (!ramp_en) begin
            cur_nxt[host_addr]  = host_code;
            pend_nxt[host_addr] = 1'b1;
         end
      end

      if (state == S_INIT) begin
         for (int b = 0; b < NUM_BANDS; b++) begin
            cur_nxt[b] = UNITY_CODE;
            tgt_nxt[b] = UNITY_CODE;
         end
         pend_nxt = '0;
      end

      busy_nxt = |pend_nxt;
      for (int b = 0; b < NUM_BANDS; b++) begin
         if (cur_nxt[b] != tgt_nxt[b]) begin
            busy_nxt = 1'b1;
         end
      end
   end

   // Controller FSM: init sweep to unity, then run with registered bank writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_INIT;
         init_cnt   <= '0;
         cur        <= '{default: UNITY_CODE};
         tgt        <= '{default: UNITY_CODE};
         pend       <= '0;
         we         <= 1'b0;
         addr       <= '0;
         data_out   <= '0;
         err        <= 1'b0;
         init_done  <= 1'b0;
         host_ready <= 1'b0;
         busy       <= 1'b1;
      end else begin
         cur  <= cur_nxt;
         tgt  <= tgt_nxt;
         pend <= pend_nxt;
         err  <= 1'b0;
         case (state)
            S_INIT: begin
               if (init_cnt < CW'(NUM_BANDS)) begin
                  we       <= 1'b1;
                  addr     <= 8'(init_cnt);
                  data_out <= UNITY_CODE;
                  init_cnt <= init_cnt + CW'(1);
                  busy     <= 1'b1;
               end else begin
                  we         <= 1'b0;
                  state      <= S_RUN;
                  init_done  <= 1'b1;
                  host_ready <= 1'b1;
                  busy       <= busy_nxt;
               end
            end
            S_RUN: begin
               we <= issue_found;
               if (issue_found) begin
                  addr     <= 8'(issue_idx);
                  data_out <= cur[issue_idx];
               end
               err  <= accept && !in_range;
               busy <= busy_nxt;
            end
            default: begin
               state <= S_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// tb_gain_ramp_ctrl: directed, table-driven bench for gain_ramp_ctrl.
// Main instance uses STEP=1, STEP_DIV=16; a second instance with STEP=16
// shares the inputs and is observed only for the clamp-at-target case.
module tb_gain_ramp_ctrl;

   logic       clk;
   logic       rst_n;
   logic       host_valid;
   logic [3:0] host_addr;
   logic [7:0] host_code;
   logic       ramp_en;

   logic       host_ready, we, err, busy, init_done;
   logic [7:0] addr, data_out;

   logic       host_ready16, we16, err16, busy16, init_done16;
   logic [7:0] addr16, data_out16;

   int check_count;
   int pass_count;

   typedef struct {
      logic       valid;
      logic [3:0] a;
      logic [7:0] code;
      logic       exp_we;
      logic [7:0] exp_addr;
      logic [7:0] exp_data;
      logic       exp_err;
      logic       exp_busy;
   } vec_t;

   vec_t vecs[8];

   gain_ramp_ctrl #(
      .NUM_BANDS(10), .UNITY_CODE(8'h20), .STEP(1), .STEP_DIV(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(host_ready),
      .host_addr(host_addr), .host_code(host_code), .ramp_en(ramp_en),
      .we(we), .addr(addr), .data_out(data_out), .err(err),
      .busy(busy), .init_done(init_done)
   );

   gain_ramp_ctrl #(
      .NUM_BANDS(10), .UNITY_CODE(8'h20), .STEP(16), .STEP_DIV(16)
   ) dut16 (
      .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_ready(host_ready16),
      .host_addr(host_addr), .host_code(host_code), .ramp_en(ramp_en),
      .we(we16), .addr(addr16), .data_out(data_out16), .err(err16),
      .busy(busy16), .init_done(init_done16)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(input logic v, input logic [3:0] a, input logic [7:0] c);
      host_valid = v;
      host_addr  = a;
      host_code  = c;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act === exp) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_init_sweep(input string tag);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_output($sformatf("%s init we[%0d]", tag, k), 32'(we), 32'd1);
         check_output($sformatf("%s init addr[%0d]", tag, k), 32'(addr), 32'(k));
         check_output($sformatf("%s init data[%0d]", tag, k), 32'(data_out), 32'h20);
         check_output($sformatf("%s init ready[%0d]", tag, k), 32'(host_ready), 32'd0);
      end
      @(negedge clk);
      check_output({tag, " init_done"}, 32'(init_done), 32'd1);
      check_output({tag, " host_ready"}, 32'(host_ready), 32'd1);
      check_output({tag, " busy after init"}, 32'(busy), 32'd0);
      check_output({tag, " we after init"}, 32'(we), 32'd0);
   endtask

   initial begin
      int n_wr;
      int w_cyc  [4];
      logic [7:0] w_addr [4];
      logic [7:0] w_data [4];

      check_count = 0;
      pass_count  = 0;
      rst_n       = 1'b0;
      ramp_en     = 1'b0;
      apply_stimulus(1'b0, 4'd0, 8'h00);

      // ramp_en=0 jump writes, back-to-back host writes, out-of-range address
      vecs[0] = '{1'b1, 4'd3,  8'h80, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 4'd0,  8'h00, 1'b1, 8'd3, 8'h80, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 4'd7,  8'h44, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 4'd2,  8'h99, 1'b1, 8'd7, 8'h44, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 4'd0,  8'h00, 1'b1, 8'd2, 8'h99, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 4'd5,  8'h11, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 4'd12, 8'h55, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 4'd0,  8'h00, 1'b0, 8'd0, 8'h00, 1'b0, 1'b0};

      // Reset values
      @(negedge clk);
      check_output("rst we", 32'(we), 32'd0);
      check_output("rst addr", 32'(addr), 32'd0);
      check_output("rst data", 32'(data_out), 32'd0);
      check_output("rst err", 32'(err), 32'd0);
      check_output("rst init_done", 32'(init_done), 32'd0);
      check_output("rst host_ready", 32'(host_ready), 32'd0);
      check_output("rst busy", 32'(busy), 32'd1);

      rst_n = 1'b1;
      check_init_sweep("first");

      // Table-driven single-cycle vectors
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].valid, vecs[i].a, vecs[i].code);
         @(negedge clk);
         check_output($sformatf("vec%0d we", i), 32'(we), 32'(vecs[i].exp_we));
         if (vecs[i].exp_we) begin
            check_output($sformatf("vec%0d addr", i), 32'(addr), 32'(vecs[i].exp_addr));
            check_output($sformatf("vec%0d data", i), 32'(data_out), 32'(vecs[i].exp_data));
         end
         check_output($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
         check_output($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      end

      // Ramp band 0 from 0x20 to 0x23 with STEP=1, tick every 16 cycles
      ramp_en = 1'b1;
      apply_stimulus(1'b1, 4'd0, 8'h23);
      n_wr = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (cyc == 1) apply_stimulus(1'b0, 4'd0, 8'h00);
         if (we === 1'b1) begin
            if (n_wr < 4) begin
               w_cyc[n_wr]  = cyc;
               w_addr[n_wr] = addr;
               w_data[n_wr] = data_out;
            end
            n_wr++;
         end
         if (cyc == 48) check_output("ramp busy mid", 32'(busy), 32'd1);
         if (cyc == 49) check_output("ramp busy done", 32'(busy), 32'd0);
      end
      check_output("ramp write count", 32'(n_wr), 32'd3);
      if (n_wr >= 3) begin
         for (int k = 0; k < 3; k++) begin
            check_output($sformatf("ramp w%0d cycle", k), 32'(w_cyc[k]), 32'(17 + 16 * k));
            check_output($sformatf("ramp w%0d addr", k), 32'(w_addr[k]), 32'd0);
            check_output($sformatf("ramp w%0d data", k), 32'(w_data[k]), 32'(8'h21 + k));
         end
      end

      // STEP=16 down-ramp of band 5 from 0x20 to 0x05 must clamp at the target
      apply_stimulus(1'b1, 4'd5, 8'h05);
      n_wr = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (cyc == 1) apply_stimulus(1'b0, 4'd0, 8'h00);
         if (we16 === 1'b1) begin
            if (n_wr < 4) begin
               w_cyc[n_wr]  = cyc;
               w_addr[n_wr] = addr16;
               w_data[n_wr] = data_out16;
            end
            n_wr++;
         end
      end
      check_output("clamp write count", 32'(n_wr), 32'd2);
      if (n_wr >= 2) begin
         check_output("clamp w0 addr", 32'(w_addr[0]), 32'd5);
         check_output("clamp w0 data", 32'(w_data[0]), 32'h10);
         check_output("clamp w1 addr", 32'(w_addr[1]), 32'd5);
         check_output("clamp w1 data", 32'(w_data[1]), 32'h05);
         check_output("clamp spacing", 32'(w_cyc[1] - w_cyc[0]), 32'd16);
      end

      // Reset in the middle of the STEP=1 ramp on band 5
      check_output("pre-reset busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("mid rst we", 32'(we), 32'd0);
      check_output("mid rst addr", 32'(addr), 32'd0);
      check_output("mid rst data", 32'(data_out), 32'd0);
      check_output("mid rst err", 32'(err), 32'd0);
      check_output("mid rst init_done", 32'(init_done), 32'd0);
      check_output("mid rst host_ready", 32'(host_ready), 32'd0);
      check_output("mid rst busy", 32'(busy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      check_init_sweep("second");

      // After the second sweep nothing should be left to ramp
      n_wr = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (we === 1'b1) n_wr++;
      end
      check_output("post-reset stray writes", 32'(n_wr), 32'd0);
      check_output("post-reset busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/gain_ramp_ctrl.md
# gain_ramp_ctrl

Controller that owns the write port of the 10-band gain register bank (`we`/`addr`/`data_in`, 8-bit gain codes converted downstream to Q5.8). It holds a per-band target and current code and accepts host target updates over a valid/ready port. The current code is stepped toward the target at a programmable rate, so band gains change without zipper noise. Each changed band is issued to the register bank as one write per cycle. After reset it sweeps every band to unity, so the bank and the controller's shadow state always agree.

## Interface
- `NUM_BANDS`, 10, number of gain bands; band addresses are 0..NUM_BANDS-1.
- `UNITY_CODE`, 8'h20, 8-bit code written to every band at init; it must be the converter's code for 1.0.
- `STEP`, 1, code increment per ramp tick, range 1..255.
- `STEP_DIV`, 4096, clock cycles per ramp tick; must be ≥ 16.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `host_valid`  in  1  host target write request.
- `host_ready`  out  1  controller can accept a host write.
- `host_addr`  in  4  band index.
- `host_code`  in  8  target gain code (unsigned).
- `ramp_en`  in  1  1 = ramp toward the target; 0 = jump immediately.
- `we`  out  1  write strobe to the register bank.
- `addr`  out  8  band address to the bank, zero-extended.
- `data_out`  out  8  gain code to the bank.
- `err`  out  1  one-cycle pulse when a host write to an out-of-range address is accepted.
- `busy`  out  1  high during init, or while any band is pending or has current ≠ target.
- `init_done`  out  1  high once the init sweep has completed.

## Operation
- Per-band state:
  - `cur[b]` and `tgt[b]`, 8-bit each.
  - `pend[b]`, 1-bit write-pending flag.
- INIT state (entered from reset):
  - Issues one write per cycle to addr 0..NUM_BANDS-1 with `data_out`=UNITY_CODE.
  - Sets all `cur`/`tgt` to UNITY_CODE and clears all `pend`.
  - Then moves to RUN and sets `init_done`=1.
  - `host_ready`=0 throughout INIT.
- RUN state:
  - `host_ready`=1 continuously; a handshake is `host_valid & host_ready` on an edge.
  - Out-of-range address (`host_addr` ≥ NUM_BANDS): the write is accepted, its data is dropped, and `err` pulses in the next cycle.
  - In-range write with `ramp_en`=0: `tgt[a]` and `cur[a]` ← `host_code`, and `pend[a]` ← 1.
  - In-range write with `ramp_en`=1: only `tgt[a]` ← `host_code`.
- Ramp prescaler:
  - Counts 0..STEP_DIV-1 while `ramp_en`=1 and wraps; it holds at 0 when `ramp_en`=0.
  - A tick occurs on the wrap cycle.
- On a tick, every band with `cur` ≠ `tgt` is updated in parallel and its `pend` is set:
  - if `cur` < `tgt`: `cur` ← min(`cur`+STEP, `tgt`);
  - otherwise: `cur` ← max(`cur`−STEP, `tgt`).
  - Arithmetic is 9-bit internally; no wrap past 0 or 255.
- Write issue:
  - Fixed priority, lowest pending index first, at most one write per cycle.
  - Registers `we`=1, `addr`=b and `data_out`=`cur[b]` (the value as of that edge), and clears `pend[b]`.
- Simultaneous events:
  - Host write and issue to the same band on the same edge: `pend` stays set, and the newer `cur` is written later.
  - Host write and tick to the same band with `ramp_en`=1: the tick steps toward the old `tgt`, and the new `tgt` is used from the next tick.
  - Host write and tick to the same band with `ramp_en`=0: no tick occurs, because the prescaler is held.
- Toggling `ramp_en` from 1 to 0 does not snap bands to their targets; only later host writes jump.

## Timing
- Reset values:
  - `we`=0, `addr`=0, `data_out`=0, `err`=0, `init_done`=0, `host_ready`=0, `busy`=1.
  - Prescaler 0; state INIT.
- INIT writes are on the outputs in cycles 1..NUM_BANDS after the first edge with `rst_n`=1. `init_done` and `host_ready` go high in the cycle after the last init write.
- All outputs are registered.
- Host handshake at edge E with `ramp_en`=0 and no other pending band: `we` is high for exactly the cycle after edge E+1.
- Tick at edge T: the first ramp write is visible after edge T+1. N changed bands give N consecutive `we` cycles.
- Because STEP_DIV ≥ 16 > NUM_BANDS, all pending writes drain before the next tick, so there is no starvation.
- An asynchronous reset in any state aborts immediately to the reset values, and INIT reruns.

## Test plan
- Reset release → 10 consecutive `we` pulses with addr 0..9 and data 8'h20 → `init_done`=1 and `busy`=0.
- `ramp_en`=0, host writes band 3 with 8'h80 → single `we` with addr 3 and data 8'h80, two edges after the handshake.
- `ramp_en`=1, STEP=1, STEP_DIV=16, band 0 target 8'h23 from 8'h20 → writes 8'h21, 8'h22, 8'h23 spaced 16 cycles apart, then `busy`=0.
- STEP=16, band 5 from 8'h20 to 8'h05 → writes 8'h10 then 8'h05 (clamped, not 8'h00).
- Host writes bands 7 and 2 on consecutive cycles with `ramp_en`=0 → the band 7 write is issued first (it is alone when issued), then band 2; host_addr 12 → `err` pulse with no `we`.
- Assert `rst_n` while a ramp is in progress → outputs return to reset values, INIT sweep repeats, and all bands end at 8'h20.
